// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, error codes and the buffered command format.
package alu_pkg;

    localparam logic [3:0] OP_ADD      = 4'b0000;
    localparam logic [3:0] OP_SUB      = 4'b0001;
    localparam logic [3:0] OP_MUL      = 4'b0010;
    localparam logic [3:0] OP_DIV      = 4'b0011;
    localparam logic [3:0] OP_MOD      = 4'b0100;
    localparam logic [3:0] OP_AND      = 4'b0101;
    localparam logic [3:0] OP_OR       = 4'b0110;
    localparam logic [3:0] OP_XOR      = 4'b0111;
    localparam logic [3:0] OP_NOT      = 4'b1000;
    localparam logic [3:0] OP_SHL      = 4'b1001;
    localparam logic [3:0] OP_SHR      = 4'b1010;
    localparam logic [3:0] OP_CMP      = 4'b1011;
    localparam logic [3:0] OP_RESET    = 4'b1100;
    localparam logic [3:0] OP_PRESET   = 4'b1101;
    localparam logic [3:0] OP_FEEDBACK = 4'b1110;
    localparam logic [3:0] OP_EXP      = 4'b1111;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_OVF  = 2'b10;

    localparam int unsigned CMD_W = 68;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [31:0] p;
        logic [31:0] q;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy, full and empty flags.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  cmd_t                   wrData,
    output cmd_t                   headData,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    cmd_t            mem [DEPTH];
    logic [PtrW-1:0] wrPtr;
    logic [PtrW-1:0] rdPtr;
    logic            doPush;
    logic            doPop;

    assign full     = (level == (PtrW + 1)'(DEPTH));
    assign empty    = (level == '0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headData = mem[rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= wrData;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (doPush && !doPop) begin
                level <= level + 1'b1;
            end else if (doPop && !doPush) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues each for one cycle and registers the ALU response.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_opcode,
    input  logic [31:0]            cmd_p,
    input  logic [31:0]            cmd_q,
    output logic [3:0]             alu_opcode,
    output logic [31:0]            alu_p,
    output logic [31:0]            alu_q,
    input  logic [31:0]            alu_result,
    input  logic [1:0]             alu_error,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_result,
    output logic [1:0]             rsp_error,
    output logic [TAG_W-1:0]       rsp_tag,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [7:0]             err_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    cmd_t       pushCmd;
    cmd_t       headCmd;
    logic       fifoFull;
    logic       fifoEmpty;
    logic       pushNow;
    logic       exec;
    logic [0:0] seqState;

    assign pushCmd   = '{opcode: cmd_opcode, p: cmd_p, q: cmd_q};
    assign cmd_ready = !fifoFull;
    assign pushNow   = cmd_valid && !fifoFull;
    assign exec      = !fifoEmpty && (!rsp_valid || rsp_ready) && rst_n;
    assign seqState  = exec ? ST_EXEC : ST_IDLE;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) uFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (pushNow),
        .pop      (exec),
        .wrData   (pushCmd),
        .headData (headCmd),
        .level    (fifo_level),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    // The ALU accumulator has no enable: FEEDBACK holds it, RESET clears it.
    always_comb begin
        alu_opcode = OP_FEEDBACK;
        alu_p      = '0;
        alu_q      = '0;
        if (!rst_n) begin
            alu_opcode = OP_RESET;
        end else begin
            case (seqState)
                ST_EXEC: begin
                    alu_opcode = headCmd.opcode;
                    alu_p      = headCmd.p;
                    alu_q      = headCmd.q;
                end
                default: begin
                    alu_opcode = OP_FEEDBACK;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_error  <= ERR_NONE;
            rsp_tag    <= '0;
            err_count  <= '0;
        end else if (exec) begin
            // A fresh capture takes priority over retiring the old response.
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_error  <= alu_error;
            rsp_tag    <= rsp_tag + 1'b1;
            if (alu_error != ERR_NONE && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU stub.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_opcode;
    logic [31:0]      cmd_p;
    logic [31:0]      cmd_q;
    logic [3:0]       alu_opcode;
    logic [31:0]      alu_p;
    logic [31:0]      alu_q;
    logic [31:0]      alu_result;
    logic [1:0]       alu_error;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [1:0]       rsp_error;
    logic [TAG_W-1:0] rsp_tag;
    logic [LW-1:0]    fifo_level;
    logic [7:0]       err_count;

    alu_cmd_sequencer #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_p      (cmd_p),
        .cmd_q      (cmd_q),
        .alu_opcode (alu_opcode),
        .alu_p      (alu_p),
        .alu_q      (alu_q),
        .alu_result (alu_result),
        .alu_error  (alu_error),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error),
        .rsp_tag    (rsp_tag),
        .fifo_level (fifo_level),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stub: combinational result, accumulator latched on every edge.
    logic [31:0] acc;
    logic [31:0] stubRes;
    logic [1:0]  stubErr;

    always_comb begin
        stubRes = '0;
        stubErr = ERR_NONE;
        case (alu_opcode)
            OP_ADD: begin
                stubRes = alu_p + alu_q;
                if (alu_p[31] == alu_q[31] && stubRes[31] != alu_p[31]) stubErr = ERR_OVF;
            end
            OP_SUB:      stubRes = alu_p - alu_q;
            OP_MUL:      stubRes = alu_p * alu_q;
            OP_AND:      stubRes = alu_p & alu_q;
            OP_XOR:      stubRes = alu_p ^ alu_q;
            OP_DIV: begin
                if (alu_q == 32'd0) stubErr = ERR_DIV0;
                else stubRes = alu_p / alu_q;
            end
            OP_PRESET:   stubRes = alu_p;
            OP_FEEDBACK: stubRes = acc;
            default:     stubRes = '0;
        endcase
    end

    assign alu_result = stubRes;
    assign alu_error  = stubErr;

    always @(posedge clk) acc <= stubRes;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] p;
        logic [31:0] q;
        logic [31:0] res;
        logic [1:0]  err;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    exp_t        expQ[$];
    exp_t        cur;
    exp_t        ent;
    logic [7:0]  curTag;
    logic [7:0]  tagModel;
    logic [7:0]  errModel;
    logic [31:0] lastRes;
    int          lvl;
    bit          vModel;
    bit          pushNow;
    bit          execNow;
    bit          randReady = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference ALU: the spec's arithmetic, with FEEDBACK returning the previous result.
    task automatic refOp(input logic [3:0] op, input logic [31:0] p, input logic [31:0] q,
                         input logic [31:0] last, output logic [31:0] r, output logic [1:0] e);
        longint s;
        r = 32'd0;
        e = ERR_NONE;
        if (op == OP_ADD) begin
            s = longint'($signed(p)) + longint'($signed(q));
            r = p + q;
            if (s > 64'sd2147483647 || s < -64'sd2147483648) e = ERR_OVF;
        end else if (op == OP_SUB) r = p - q;
        else if (op == OP_MUL) r = p * q;
        else if (op == OP_AND) r = p & q;
        else if (op == OP_XOR) r = p ^ q;
        else if (op == OP_DIV) begin
            if (q == 0) e = ERR_DIV0;
            else r = p / q;
        end else if (op == OP_PRESET) r = p;
        else if (op == OP_FEEDBACK) r = last;
    endtask

    // Monitor / scoreboard, sampling on the falling edge.
    initial begin
        lvl = 0; vModel = 0; tagModel = 0; errModel = 0; lastRes = 0; curTag = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rstOpcode", 32'(alu_opcode), 32'(OP_RESET));
                chk("rstPQ", alu_p | alu_q, 32'd0);
                lvl = 0; vModel = 0; tagModel = 0; errModel = 0; lastRes = 0;
                expQ.delete();
            end else begin
                chk("cmdReady", 32'(cmd_ready), 32'(lvl != DEPTH));
                chk("fifoLevel", 32'(fifo_level), lvl);
                chk("rspValid", 32'(rsp_valid), 32'(vModel));
                chk("errCount", 32'(err_count), 32'(errModel));
                pushNow = cmd_valid && (lvl != DEPTH);
                execNow = (lvl != 0) && (!vModel || rsp_ready);
                if (vModel) begin
                    chk("rspResult", rsp_result, cur.res);
                    chk("rspError", 32'(rsp_error), 32'(cur.err));
                    chk("rspTag", 32'(rsp_tag), 32'(curTag));
                end
                if (execNow) begin
                    if (expQ.size() == 0) begin
                        total++; bad++;
                        $display("FAIL issueQueue: got empty want entry at %0t", $time);
                    end else begin
                        ent = expQ.pop_front();
                        chk("issueOp", 32'(alu_opcode), 32'(ent.op));
                        chk("issueP", alu_p, ent.p);
                        chk("issueQ", alu_q, ent.q);
                        cur = ent;
                        tagModel = tagModel + 8'd1;
                        curTag = tagModel;
                        if (ent.err != ERR_NONE && errModel != 8'hFF) errModel = errModel + 8'd1;
                    end
                end else begin
                    chk("idleOp", 32'(alu_opcode), 32'(OP_FEEDBACK));
                    chk("idlePQ", alu_p | alu_q, 32'd0);
                end
                if (pushNow) begin
                    ent.op = cmd_opcode; ent.p = cmd_p; ent.q = cmd_q;
                    refOp(cmd_opcode, cmd_p, cmd_q, lastRes, ent.res, ent.err);
                    lastRes = ent.res;
                    expQ.push_back(ent);
                end
                lvl = lvl + (pushNow ? 1 : 0) - (execNow ? 1 : 0);
                vModel = execNow ? 1'b1 : (rsp_ready ? 1'b0 : vModel);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randReady) rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic sendCmd(input logic [3:0] op, input logic [31:0] p, input logic [31:0] q);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_p = p; cmd_q = q;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL sendTimeout: got cmd_ready=0 want 1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || lvl != 0 || vModel) && n < 2000) begin
            n++;
            @(posedge clk);
            #1;
        end
        total++;
        if (expQ.size() != 0 || lvl != 0 || vModel) begin
            bad++;
            $display("FAIL drainTimeout: got %0d pending want 0", expQ.size());
        end
    endtask

    task automatic doReset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstTag", 32'(rsp_tag), 32'd0);
        chk("rstErrCount", 32'(err_count), 32'd0);
        chk("rstResult", rsp_result, 32'd0);
        chk("rstError", 32'(rsp_error), 32'd0);
        chk("rstLevel", 32'(fifo_level), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [3:0] ops [9] = '{OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_XOR, OP_DIV,
                            OP_PRESET, OP_FEEDBACK, OP_RESET};

    initial begin
        logic [31:0] rp;
        logic [31:0] rq;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_p = '0; cmd_q = '0;
        rsp_ready = 1'b1;
        #1;
        doReset(2);

        sendCmd(OP_ADD, 32'd5, 32'd3);
        drain();

        sendCmd(OP_DIV, 32'd7, 32'd0);
        sendCmd(OP_ADD, 32'h7FFF_FFFF, 32'd1);
        drain();
        chk("errCountTwo", 32'(err_count), 32'd2);

        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) sendCmd(OP_SUB, 32'(100 + i), 32'(i));
        repeat (2) @(negedge clk);
        chk("fullLevel", 32'(fifo_level), 32'd4);
        chk("fullReady", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain();

        for (int i = 0; i < 10; i++) sendCmd(OP_ADD, $urandom, $urandom_range(0, 1000));
        drain();

        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) sendCmd(OP_XOR, $urandom, $urandom);
        doReset(2);
        rsp_ready = 1'b1;
        sendCmd(OP_ADD, 32'd1, 32'd2);
        drain();

        for (int i = 0; i < 260; i++) sendCmd(OP_DIV, $urandom, 32'd0);
        drain();
        chk("errSaturate", 32'(err_count), 32'd255);

        sendCmd(OP_PRESET, 32'h1234_5678, 32'd0);
        sendCmd(OP_FEEDBACK, 32'd0, 32'd0);
        sendCmd(OP_RESET, 32'd9, 32'd9);
        sendCmd(OP_FEEDBACK, 32'd0, 32'd0);
        drain();

        randReady = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rp = $urandom;
            rq = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) rp = 32'h7FFF_FFFF;
            sendCmd(ops[$urandom_range(0, 8)], rp, rq);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        randReady = 1'b0;
        rsp_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL globalTimeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream stage of the ALU. It accepts operation commands (opcode plus two 32-bit operands) from the middleware-facing side over a valid/ready handshake and buffers them in a small FIFO. It issues each command to the ALU for exactly one clock, then captures the ALU's combinational result and error code into a response register. The ALU's accumulator register has no enable, so this block drives the FEEDBACK opcode (1110) on every non-issue cycle to hold the ALU state.

Parameters:
DEPTH, 4, command FIFO entries; power of two, minimum 2.
TAG_W, 8, width of the per-response sequence tag.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  synchronous, active-low reset.
cmd_valid  in  1  command-side valid.
cmd_ready  out  1  command-side ready; equals "FIFO not full".
cmd_opcode  in  4  ALU opcode (0000 add … 1111 exponent).
cmd_p  in  32  operand P.
cmd_q  in  32  operand Q.
alu_opcode  out  4  opcode driven to the ALU.
alu_p  out  32  operand P driven to the ALU.
alu_q  out  32  operand Q driven to the ALU.
alu_result  in  32  ALU combinational output (outALU).
alu_error  in  2  ALU errorCode: 00 none, 01 divide by zero, 10 overflow.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response ready.
rsp_result  out  32  captured result.
rsp_error  out  2  captured error code.
rsp_tag  out  TAG_W  sequence number of the response.
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
err_count  out  8  saturating count of responses with a non-zero error.

Behaviour:
- Reset (rst_n low at an edge) clears the FIFO pointers and level, rsp_valid, rsp_result, rsp_error, rsp_tag and err_count to 0.
- While rst_n is low, alu_opcode is forced to 1100 (RESET) with alu_p = alu_q = 0, so the ALU accumulator clears on the same edges.
- Reset asserted mid-operation discards all queued commands and any pending response; nothing is replayed.
- Push: on an edge with cmd_valid && cmd_ready, {opcode, p, q} is written to the FIFO tail.
- Full FIFO: cmd_ready is 0 and nothing is written.
- exec (combinational) = FIFO not empty && (!rsp_valid || rsp_ready) && rst_n.
- exec = 1 cycle:
  - alu_opcode, alu_p and alu_q come from the FIFO head.
  - At the edge: pop the head; rsp_result <= alu_result; rsp_error <= alu_error; rsp_valid <= 1; rsp_tag <= rsp_tag + 1 (first response carries tag 1; wraps modulo 2^TAG_W).
  - If alu_error != 0, err_count increments, saturating at 255.
- exec = 0 cycle: alu_opcode = 1110 (FEEDBACK) and alu_p = alu_q = 0. The ALU state is unchanged.
- Response handshake:
  - On rsp_valid && rsp_ready without exec, rsp_valid <= 0.
  - Handshake and exec in the same cycle: the new capture wins and rsp_valid stays 1. This sustains one command per cycle.
- Simultaneous push and pop in one cycle: fifo_level is unchanged. A push is allowed when the FIFO is full and pops the same cycle only if cmd_ready says so; cmd_ready is strictly "not full", so no push occurs on that cycle.
- Latency: a command pushed at edge k into an empty FIFO executes in cycle k→k+1; rsp_valid is high after edge k+1. Best-case throughput is 1 command per clock.
- rsp_result, rsp_error and rsp_tag hold stable while rsp_valid && !rsp_ready.
- The 1110/1100/1101 opcodes are legal commands and are issued like any other.
- FSM: implicit two states, derived from FIFO state and rsp_valid:
  - IDLE/HOLD (drive FEEDBACK).
  - EXEC (drive head).
  - No multi-cycle states.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode localparams OP_ADD … OP_EXP, including OP_RESET = 4'b1100, OP_PRESET = 4'b1101, OP_FEEDBACK = 4'b1110;
  - the error codes ERR_NONE = 2'b00, ERR_DIV0 = 2'b01, ERR_OVF = 2'b10;
  - the command struct/width constant CMD_W = 68.
- One sub-module, alu_cmd_fifo: a synchronous FIFO with push, pop, head data, level, full and empty, reset by rst_n.

Test Plan:
- Bench drives alu_result and alu_error from a behavioural ALU stub (P op Q, 1110 returns the last latched value).
- Push add P=5, Q=3 into an idle block → one cycle with alu_opcode=0000, alu_p=5, alu_q=3; next cycle rsp_valid=1, rsp_result=8, rsp_error=00, rsp_tag=1. Otherwise alu_opcode=1110.
- Push division P=7, Q=0 with the stub returning error 01 → rsp_error=01, err_count=1. Then push add 0x7FFFFFFF+1 with the stub returning error 10 → rsp_error=10, err_count=2.
- Hold rsp_ready=0 and push 5 commands with DEPTH=4:
  - after the first executes, the next 4 fill the FIFO, cmd_ready=0 and fifo_level=4;
  - alu_opcode stays 1110 throughout;
  - raising rsp_ready drains 4 responses on consecutive cycles with tags 2..5.
- Keep rsp_ready=1 and stream 10 back-to-back adds → 10 consecutive rsp_valid cycles, tags 1..10, fifo_level never exceeds 1.
- Assert rst_n=0 for 2 cycles with 3 commands queued and rsp_valid=1:
  - alu_opcode=1100 during reset;
  - afterwards fifo_level=0, rsp_valid=0, rsp_tag=0, err_count=0;
  - the first new command returns tag 1.
- Drive 260 error responses → err_count saturates at 255. rsp_tag wraps 255→0 at the 256th response.
